// File: rtl/snake_body_ring.sv
// rtl/snake_body_ring.sv - circular store of snake body segments with a head-to-tail scan port
// Optional feature macro: SNAKE_HIT_DETECT_EN (adds probe_x/probe_y/hit self-collision compare)
`timescale 1ns/1ps

module snake_body_ring #(
   parameter int COORD_W = 12,
   parameter int DEPTH   = 500
) (
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic [COORD_W-1:0]           head_x,
   input  logic [COORD_W-1:0]           head_y,
   input  logic                         move,
   input  logic                         grow,
   output logic [$clog2(DEPTH+1)-1:0]   length,
   output logic                         empty,
   output logic                         full,
   output logic                         overflow,
   output logic                         drop,
   input  logic                         scan_start,
   output logic                         scan_busy,
   output logic [COORD_W-1:0]           seg_x,
   output logic [COORD_W-1:0]           seg_y,
   output logic                         seg_valid,
   input  logic                         seg_ready,
   output logic                         seg_last,
   output logic                         scan_done
`ifdef SNAKE_HIT_DETECT_EN
   ,
   input  logic [COORD_W-1:0]           probe_x,
   input  logic [COORD_W-1:0]           probe_y,
   output logic                         hit
`endif
);

   localparam int LEN_W = $clog2(DEPTH + 1);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int SEG_W = 2 * COORD_W;

   localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(DEPTH);
   localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_LOAD = 2'd1,
      S_SEND = 2'd2
   } scan_state_t;

   // Segment storage; never cleared, only the length/pointers define what is live.
   logic [SEG_W-1:0] mem [DEPTH];

   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] wr_ptr_next;
   logic [PTR_W-1:0] head_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] rd_ptr_prev;
   logic [LEN_W-1:0] remain;
   logic             req;
   logic             wr_en;
   scan_state_t      state;

   // Requests arriving while a scan is running are refused so the scan sees a frozen ring.
   assign req   = move | grow;
   assign wr_en = req & ~scan_busy;

   assign empty = (length == '0);
   assign full  = (length == LEN_MAX);

   // Pointer arithmetic with explicit wrap so DEPTH need not be a power of two.
   assign wr_ptr_next = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PTR_ONE;
   assign head_ptr    = (wr_ptr == '0) ? PTR_LAST : wr_ptr - PTR_ONE;
   assign rd_ptr_prev = (rd_ptr == '0) ? PTR_LAST : rd_ptr - PTR_ONE;

   // Store the new head at the write slot.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr] <= {head_x, head_y};
      end
   end

   // Track write pointer and length; grow beats move, full grow degrades to move, empty move acts as grow.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr   <= '0;
         length   <= '0;
         overflow <= 1'b0;
         drop     <= 1'b0;
      end else begin
         overflow <= 1'b0;
         drop     <= 1'b0;
         if (req && scan_busy) begin
            drop <= 1'b1;
         end else if (req) begin
            wr_ptr <= wr_ptr_next;
            if (grow) begin
               if (length == LEN_MAX) begin
                  overflow <= 1'b1;
               end else begin
                  length <= length + LEN_ONE;
               end
            end else if (length == '0) begin
               length <= LEN_ONE;
            end
         end
      end
   end

   // Scan engine: walks from head to tail, one registered read per segment, all outputs registered.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= S_IDLE;
         rd_ptr    <= '0;
         remain    <= '0;
         scan_busy <= 1'b0;
         seg_valid <= 1'b0;
         seg_last  <= 1'b0;
         seg_x     <= '0;
         seg_y     <= '0;
         scan_done <= 1'b0;
      end else begin
         scan_done <= 1'b0;
         case (state)
            S_IDLE: begin
               if (scan_start) begin
                  if (length != '0) begin
                     rd_ptr    <= head_ptr;
                     remain    <= length;
                     scan_busy <= 1'b1;
                     state     <= S_LOAD;
                  end else begin
                     scan_done <= 1'b1;
                  end
               end
            end
            S_LOAD: begin
               {seg_x, seg_y} <= mem[rd_ptr];
               seg_valid      <= 1'b1;
               seg_last       <= (remain == LEN_ONE);
               state          <= S_SEND;
            end
            S_SEND: begin
               if (seg_ready) begin
                  seg_valid <= 1'b0;
                  seg_last  <= 1'b0;
                  if (remain > LEN_ONE) begin
                     rd_ptr <= rd_ptr_prev;
                     remain <= remain - LEN_ONE;
                     state  <= S_LOAD;
                  end else begin
                     scan_busy <= 1'b0;
                     scan_done <= 1'b1;
                     state     <= S_IDLE;
                  end
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

`ifdef SNAKE_HIT_DETECT_EN
   logic [COORD_W-1:0] probe_x_q;
   logic [COORD_W-1:0] probe_y_q;
   logic               at_head;
   logic               xfer;

   assign xfer = (state == S_SEND) & seg_ready;

   // Sticky compare of every non-head transferred segment against the probe captured at scan start.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         probe_x_q <= '0;
         probe_y_q <= '0;
         at_head   <= 1'b0;
         hit       <= 1'b0;
      end else if ((state == S_IDLE) && scan_start) begin
         probe_x_q <= probe_x;
         probe_y_q <= probe_y;
         at_head   <= 1'b1;
         hit       <= 1'b0;
      end else if (xfer) begin
         at_head <= 1'b0;
         if (!at_head && (seg_x == probe_x_q) && (seg_y == probe_y_q)) begin
            hit <= 1'b1;
         end
      end
   end
`endif

endmodule
